// File: rtl/aes_ctrl_fsm_pkg.sv
// Shared types for the AES control slice: controller state encoding and default block stride.
package aes_package;

   typedef enum logic [2:0] {
      IDLE,
      STARTING,
      WORKING,
      NEXT,
      FINISHED
   } aes_ctrl_state_t;

   localparam int unsigned AES_BLOCK_BYTES = 16;

endpackage

// File: rtl/aes_ctrl_fsm_blk_counter.sv
// Block index counter for aes_ctrl_fsm: zeroed on job load or clear, stepped once per block,
// and flags the final block of the job.
module aes_blk_counter #(
   parameter int unsigned BLK_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 load_zero,
   input  logic                 inc,
   input  logic [BLK_CNT_W-1:0] count,
   output logic [BLK_CNT_W-1:0] idx,
   output logic                 last
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx <= '0;
      end else if (clear || load_zero) begin
         idx <= '0;
      end else if (inc) begin
         idx <= idx + BLK_CNT_W'(1);
      end
   end

   // count is nonzero whenever last is consulted, so count-1 never underflows in use
   assign last = (idx == (count - BLK_CNT_W'(1)));

endmodule

// File: rtl/aes_ctrl_fsm.sv
// aes_ctrl_fsm: sequences a multi-block AES job across source/sink streamers and the engine.
// Optional watchdog compiled in only when AES_CTRL_FSM_TIMEOUT_EN is defined.
module aes_ctrl_fsm
   import aes_package::*;
#(
   parameter int unsigned BLK_CNT_W      = 16,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned BLOCK_BYTES    = AES_BLOCK_BYTES,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 start_i,
   input  logic [BLK_CNT_W-1:0] n_blocks_i,
   input  logic [ADDR_W-1:0]    src_base_i,
   input  logic [ADDR_W-1:0]    dst_base_i,
   input  logic                 src_ready_i,
   input  logic                 dst_ready_i,
   output logic                 src_req_o,
   output logic                 dst_req_o,
   output logic [ADDR_W-1:0]    src_addr_o,
   output logic [ADDR_W-1:0]    dst_addr_o,
   output logic                 eng_clear_o,
   output logic                 eng_start_o,
   output logic                 eng_enable_o,
   input  logic                 eng_done_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [BLK_CNT_W-1:0] blk_idx_o
);

   aes_ctrl_state_t      state_q, state_d;
   logic [BLK_CNT_W-1:0] n_blocks_q;
   logic [ADDR_W-1:0]    src_base_q, dst_base_q;
   logic [BLK_CNT_W-1:0] blk_idx;
   logic                 blk_last;
   logic                 job_load;
   logic                 blk_inc;
   logic                 timeout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else if (clear) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      job_load     = 1'b0;
      blk_inc      = 1'b0;
      src_req_o    = 1'b0;
      dst_req_o    = 1'b0;
      eng_clear_o  = 1'b0;
      eng_start_o  = 1'b0;
      eng_enable_o = 1'b0;
      done_o       = 1'b0;
      unique case (state_q)
         IDLE: begin
            eng_clear_o = 1'b1;
            if (start_i) begin
               job_load = 1'b1;
               state_d  = (n_blocks_i == '0) ? FINISHED : STARTING;
            end
         end
         STARTING: begin
            src_req_o    = 1'b1;
            dst_req_o    = 1'b1;
            eng_start_o  = 1'b1;
            eng_enable_o = 1'b1;
            if (timeout) begin
               state_d = FINISHED;
            end else if (src_ready_i && dst_ready_i) begin
               state_d = WORKING;
            end
         end
         WORKING: begin
            eng_enable_o = 1'b1;
            if (timeout) begin
               state_d = FINISHED;
            end else if (eng_done_i) begin
               state_d = blk_last ? FINISHED : NEXT;
            end
         end
         NEXT: begin
            eng_enable_o = 1'b1;
            blk_inc      = 1'b1;
            state_d      = STARTING;
         end
         FINISHED: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Addresses come from the latched job so base inputs may change freely mid-job
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_blocks_q <= '0;
         src_base_q <= '0;
         dst_base_q <= '0;
      end else if (clear) begin
         n_blocks_q <= '0;
         src_base_q <= '0;
         dst_base_q <= '0;
      end else if (job_load) begin
         n_blocks_q <= n_blocks_i;
         src_base_q <= src_base_i;
         dst_base_q <= dst_base_i;
      end
   end

   aes_blk_counter #(
      .BLK_CNT_W(BLK_CNT_W)
   ) u_blk_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .load_zero(job_load),
      .inc      (blk_inc),
      .count    (n_blocks_q),
      .idx      (blk_idx),
      .last     (blk_last)
   );

   assign src_addr_o = src_base_q + (ADDR_W'(blk_idx) * ADDR_W'(BLOCK_BYTES));
   assign dst_addr_o = dst_base_q + (ADDR_W'(blk_idx) * ADDR_W'(BLOCK_BYTES));
   assign blk_idx_o  = blk_idx;
   assign busy_o     = (state_q != IDLE);

`ifdef AES_CTRL_FSM_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wdog_q;
   logic            wd_active;
   logic            err_q;

   assign wd_active = (state_q == STARTING) || (state_q == WORKING);
   assign timeout   = wd_active && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Any state change restarts the count, covering every entry into STARTING or WORKING
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else if (clear) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_d != state_q) begin
            wdog_q <= '0;
         end else if (wd_active) begin
            wdog_q <= wdog_q + WD_W'(1);
         end
         if (job_load) begin
            err_q <= 1'b0;
         end else if (timeout) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ctrl_fsm.sv
// Self-checking bench for aes_ctrl_fsm: vector table of whole jobs with an address scoreboard,
// plus directed stall, clear, watchdog (AES_CTRL_FSM_TIMEOUT_EN) and async reset sequences.
module tb_aes_ctrl_fsm;

   typedef struct {
      logic [15:0] n;
      logic [31:0] src;
      logic [31:0] dst;
      int unsigned k;
      int unsigned exp_cyc;
   } vec_t;

   typedef struct {
      logic [15:0] idx;
      logic [31:0] src;
      logic [31:0] dst;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] n_blocks_i = '0;
   logic [31:0] src_base_i = '0;
   logic [31:0] dst_base_i = '0;
   logic        src_ready_i = 1'b1;
   logic        dst_ready_i = 1'b1;
   logic        eng_done_i = 1'b0;
   logic        src_req_o, dst_req_o, eng_clear_o, eng_start_o, eng_enable_o;
   logic        busy_o, done_o, err_o;
   logic [31:0] src_addr_o, dst_addr_o;
   logic [15:0] blk_idx_o;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;
   int unsigned eng_k = 0;
   int unsigned wcnt = 0;
   exp_t        sb_q[$];
   vec_t        vecs[4];

   aes_ctrl_fsm #(
      .BLK_CNT_W     (16),
      .ADDR_W        (32),
      .BLOCK_BYTES   (16),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (clear),
      .start_i     (start_i),
      .n_blocks_i  (n_blocks_i),
      .src_base_i  (src_base_i),
      .dst_base_i  (dst_base_i),
      .src_ready_i (src_ready_i),
      .dst_ready_i (dst_ready_i),
      .src_req_o   (src_req_o),
      .dst_req_o   (dst_req_o),
      .src_addr_o  (src_addr_o),
      .dst_addr_o  (dst_addr_o),
      .eng_clear_o (eng_clear_o),
      .eng_start_o (eng_start_o),
      .eng_enable_o(eng_enable_o),
      .eng_done_i  (eng_done_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .blk_idx_o   (blk_idx_o)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Engine model and scoreboard: each accepted STARTING pops the expected block record
   always @(negedge clk) begin
      #2;
      eng_done_i = 1'b0;
      if (wcnt != 0) begin
         wcnt--;
         if (wcnt == 0) eng_done_i = 1'b1;
      end
      if (eng_start_o && src_ready_i && dst_ready_i) begin
         exp_t e;
         wcnt = eng_k;
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'(sb_q.size()), 64'd1);
         end else begin
            e = sb_q.pop_front();
            chk("sb_blk_idx", 64'(blk_idx_o), 64'(e.idx));
            chk("sb_src_addr", 64'(src_addr_o), 64'(e.src));
            chk("sb_dst_addr", 64'(dst_addr_o), 64'(e.dst));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drives start_i in cycle 1 and returns at the drive point of cycle 2
   task automatic start_job(input logic [15:0] n, input logic [31:0] s, input logic [31:0] d,
                            input int unsigned k);
      for (int unsigned i = 0; i < 32'(n); i++)
         sb_q.push_back('{idx: 16'(i), src: s + 32'(i) * 32'd16, dst: d + 32'(i) * 32'd16});
      eng_k = k;
      cyc();
      start_i    = 1'b1;
      n_blocks_i = n;
      src_base_i = s;
      dst_base_i = d;
      @(negedge clk);
      cyc();
      start_i = 1'b0;
   endtask

   task automatic run_job(input vec_t v);
      int unsigned got;
      logic        any_req;
      got     = 0;
      any_req = 1'b0;
      start_job(v.n, v.src, v.dst, v.k);
      for (int unsigned c = 2; c <= 400; c++) begin
         @(negedge clk);
         if (src_req_o || eng_start_o) any_req = 1'b1;
         if (done_o) begin
            got = c;
            break;
         end
         cyc();
         src_base_i = $urandom;
         dst_base_i = $urandom;
      end
      chk("done_latency", 64'(got), 64'(v.exp_cyc));
      chk("req_seen", 64'(any_req), 64'(v.n != 0));
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      cyc();
      @(negedge clk);
      chk("done_one_cycle", 64'(done_o), 64'd0);
      chk("idle_after_job", 64'(busy_o), 64'd0);
   endtask

   initial begin
      int unsigned hold_cnt;
      int unsigned done_cnt;
      int unsigned got;
      vecs[0] = '{n: 16'd3, src: 32'h0000_1000, dst: 32'h0000_2000, k: 4, exp_cyc: 19};
      vecs[1] = '{n: 16'd0, src: 32'h0000_3000, dst: 32'h0000_4000, k: 4, exp_cyc: 2};
      vecs[2] = '{n: 16'd1, src: 32'hFFFF_FFF0, dst: 32'h0000_0010, k: 1, exp_cyc: 4};
      vecs[3] = '{n: 16'd2, src: 32'hFFFF_FFF8, dst: 32'h8000_0000, k: 2, exp_cyc: 9};

      @(negedge clk);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_reqs", 64'({src_req_o, dst_req_o, eng_start_o, eng_enable_o}), 64'd0);
      chk("rst_eng_clear", 64'(eng_clear_o), 64'd1);
      chk("rst_addr", 64'({src_addr_o, dst_addr_o}), 64'd0);
      chk("rst_blk_idx", 64'(blk_idx_o), 64'd0);
      cyc();
      reset_n = 1'b1;

      foreach (vecs[i]) run_job(vecs[i]);

      // Source streamer stalls for five STARTING cycles
      src_ready_i = 1'b0;
      hold_cnt    = 0;
      start_job(16'd1, 32'h0000_5000, 32'h0000_6000, 2);
      for (int unsigned c = 2; c <= 6; c++) begin
         @(negedge clk);
         if (src_req_o && dst_req_o && eng_start_o && eng_enable_o && busy_o) hold_cnt++;
         cyc();
      end
      chk("stall_hold_cycles", 64'(hold_cnt), 64'd5);
      src_ready_i = 1'b1;
      @(negedge clk);
      chk("stall_release_starting", 64'(eng_start_o), 64'd1);
      cyc();
      @(negedge clk);
      chk("stall_working", 64'({eng_start_o, eng_enable_o}), 64'b01);
      got = 0;
      for (int unsigned c = 9; c <= 40; c++) begin
         cyc();
         @(negedge clk);
         if (done_o) begin
            got = c;
            break;
         end
      end
      chk("stall_done_cycle", 64'(got), 64'd10);
      chk("stall_sb_drained", 64'(sb_q.size()), 64'd0);

      // Clear during block 2 of 4, with a stray start while busy
      done_cnt = 0;
      start_job(16'd4, 32'h0000_0100, 32'h0000_0200, 4);
      for (int unsigned c = 2; c <= 9; c++) begin
         @(negedge clk);
         if (done_o) done_cnt++;
         cyc();
         if (c + 1 == 4) begin
            start_i    = 1'b1;
            n_blocks_i = 16'd1;
         end
         if (c + 1 == 5) start_i = 1'b0;
         if (c + 1 == 10) clear = 1'b1;
      end
      @(negedge clk);
      chk("clr_pre_blk_idx", 64'(blk_idx_o), 64'd1);
      chk("clr_pre_working", 64'({busy_o, eng_start_o, eng_enable_o}), 64'b101);
      cyc();
      clear = 1'b0;
      @(negedge clk);
      chk("clr_idle", 64'(busy_o), 64'd0);
      chk("clr_blk_idx", 64'(blk_idx_o), 64'd0);
      chk("clr_eng_clear", 64'(eng_clear_o), 64'd1);
      chk("clr_addr", 64'({src_addr_o, dst_addr_o}), 64'd0);
      for (int unsigned c = 0; c < 8; c++) begin
         cyc();
         @(negedge clk);
         if (done_o || busy_o) done_cnt++;
      end
      chk("clr_no_done", 64'(done_cnt), 64'd0);
      chk("clr_sb_left", 64'(sb_q.size()), 64'd2);
      sb_q.delete();

      // Engine never answers
      done_cnt = 0;
      hold_cnt = 0;
      start_job(16'd1, 32'h0000_7000, 32'h0000_8000, 0);
`ifdef AES_CTRL_FSM_TIMEOUT_EN
      for (int unsigned c = 2; c <= 18; c++) begin
         @(negedge clk);
         if (done_o || err_o) done_cnt++;
         if (c >= 3 && busy_o && eng_enable_o && !eng_start_o) hold_cnt++;
         cyc();
      end
      chk("wd_early_done", 64'(done_cnt), 64'd0);
      chk("wd_working_cycles", 64'(hold_cnt), 64'd16);
      @(negedge clk);
      chk("wd_done", 64'(done_o), 64'd1);
      chk("wd_err", 64'(err_o), 64'd1);
      cyc();
      @(negedge clk);
      chk("wd_err_sticky", 64'({busy_o, err_o}), 64'b01);
      start_job(16'd0, 32'h0, 32'h0, 0);
      @(negedge clk);
      chk("wd_err_cleared", 64'({done_o, err_o}), 64'b10);
      start_job(16'd2, 32'h0000_9000, 32'h0000_9100, 8);
      for (int unsigned c = 0; c < 4; c++) cyc();
`else
      for (int unsigned c = 2; c <= 40; c++) begin
         @(negedge clk);
         if (done_o || err_o) done_cnt++;
         if (c >= 3 && busy_o && eng_enable_o && !eng_start_o) hold_cnt++;
         cyc();
      end
      chk("nowd_no_done", 64'(done_cnt), 64'd0);
      chk("nowd_stuck_working", 64'(hold_cnt), 64'd38);
`endif

      // Asynchronous reset mid-job: outputs drop before any clock edge
      reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_state_outs", 64'({eng_clear_o, eng_enable_o, src_req_o}), 64'b100);
      chk("arst_blk_idx", 64'(blk_idx_o), 64'd0);
      chk("arst_err", 64'(err_o), 64'd0);
      done_cnt = 0;
      for (int unsigned c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done_o) done_cnt++;
      end
      chk("arst_no_done", 64'(done_cnt), 64'd0);
      sb_q.delete();
      cyc();
      reset_n = 1'b1;
      run_job(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected completion");
      $fatal(1, "bench time limit");
   end

endmodule
